// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// The master drives operands and start; the slave (the adder) returns status and results.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell and a carry flop resolve one bit per clock.
// Produces sum, unsigned carry-out and signed overflow with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
  logic             c_q, cout_q, ovf_q, busy_q, done_q;
  logic [CW-1:0]    cnt_q;

  logic             s_bit, c_next;
  logic [WIDTH-1:0] acc_next;

  assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign acc_next = {s_bit, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            c_q     <= bus.cin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          acc_q <= acc_next;
          c_q   <= c_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LastCnt) begin
            // On the MSB step c_q is the carry into the MSB, so overflow is carry-in ^ carry-out.
            sum_q   <= acc_next;
            cout_q  <= c_next;
            ovf_q   <= c_q ^ c_next;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results, a monitor pops on done.
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_res(input logic [7:0] s, input logic c, input logic o);
    res_t r;
    r.sum  = s;
    r.cout = c;
    r.ovf  = o;
    exp_q.push_back(r);
  endtask

  // Monitor: samples just after each rising edge and scores every done pulse.
  initial begin
    res_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        chk("done_busy_excl", {31'd0, bus.busy}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", {24'd0, bus.sum}, {24'd0, e.sum});
          chk("cout", {31'd0, bus.cout}, {31'd0, e.cout});
          chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
        end
      end
    end
  end

  // One operation; poke >= 1 re-asserts start with junk operands in that RUN cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input logic eo, input int poke);
    int busy_n = 0;
    int n = 0;
    bit seen = 0;
    expect_res(es, ec, eo);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    @(negedge clk);
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.cin = ~cin;
    while (!seen && n < 30) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) seen = 1;
      if (bus.busy === 1'b1 && busy_n == poke) begin
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_cycles", busy_n, 32'd8);
  endtask

  initial begin
    int gap;
    bit stray;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum", {24'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    rst = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, -1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1);
    run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, -1);
    run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, -1);
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3);

    // Back-to-back with start held high through DONE.
    expect_res(8'h30, 1'b0, 1'b0);
    expect_res(8'h08, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    @(negedge clk);
    bus.a = 8'hAA; bus.b = 8'hBB;
    gap = 0;
    while (bus.done !== 1'b1 && gap < 30) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_first_done", {31'd0, bus.done}, 32'd1);
    bus.a = 8'h05; bus.b = 8'h03; bus.cin = 1'b0;
    @(negedge clk);
    gap = 1;
    chk("b2b_accept_busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b_done_pulse", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0; bus.a = 8'hCC; bus.b = 8'hDD;
    while (bus.done !== 1'b1 && gap < 30) begin
      @(negedge clk);
      gap++;
      if (gap == 4) chk("b2b_sum_hold", {24'd0, bus.sum}, 32'h30);
    end
    chk("b2b_gap", gap, 32'd9);

    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, -1);

    // Asynchronous reset mid-RUN discards the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h0A; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_done", {31'd0, bus.done}, 32'd0);
    chk("async_sum", {24'd0, bus.sum}, 32'd0);
    chk("async_cout", {31'd0, bus.cout}, 32'd0);
    chk("async_ovf", {31'd0, bus.ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) stray = 1;
    end
    chk("async_idle", {31'd0, stray}, 32'd0);

    run_op(8'h55, 8'h0A, 1'b1, 8'h60, 1'b0, 1'b0, -1);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
